// File: rtl/i2s_sequencer_if.sv
// Control, sample-memory and I2S serial signals of the sequencer as one bundle.
interface i2s_sequencer_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 7
);
   logic              start;
   logic              stop;
   logic [ADDR_W:0]   depth;
   logic [15:0]       repeats;
   logic [2:0]        volume;
   logic              mute_l;
   logic              mute_r;
   logic [ADDR_W-1:0] rom_addr;
   logic [WIDTH-1:0]  rom_data;
   logic              busy;
   logic              done;
   logic              LRCLK;
   logic              SCLK;
   logic              SD;

   // The sequencer side.
   modport slave (
      input  start, stop, depth, repeats, volume, mute_l, mute_r, rom_data,
      output rom_addr, busy, done, LRCLK, SCLK, SD
   );

   // The controller / memory / receiver side.
   modport master (
      output start, stop, depth, repeats, volume, mute_l, mute_r, rom_data,
      input  rom_addr, busy, done, LRCLK, SCLK, SD
   );
endinterface

// File: rtl/i2s_sequencer.sv
// i2s_sequencer: reads mono samples from a sample memory, applies volume and
// per-slot mute, and streams them as identical left/right I2S slots.
module i2s_sequencer #(
   parameter int WIDTH    = 16,
   parameter int HALF_DIV = 10,
   parameter int ADDR_W   = 7
) (
   input  logic           MCLK,
   input  logic           Reset,
   i2s_sequencer_if.slave bus
);
   localparam int FW    = 2 * WIDTH;
   localparam int DIV_W = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
   localparam int BIT_W = $clog2(FW);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_LOAD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [DIV_W-1:0]  div;
   logic              sclk;
   logic              lrclk;
   logic              sd;
   logic [BIT_W-1:0]  bit_cnt;
   logic [BIT_W-1:0]  bit_next;
   logic [FW-1:0]     shreg;
   logic [FW-1:0]     frame_word;
   logic [ADDR_W-1:0] rom_addr;
   logic [WIDTH-1:0]  hold;
   logic [ADDR_W:0]   depth_l;
   logic [ADDR_W:0]   depth_m1;
   logic [15:0]       repeats_l;
   logic [15:0]       pass_cnt;
   logic [15:0]       pass_inc;
   logic              stop_lat;
   logic              stop_now;
   logic              stop_hit;
   logic              fetch_wait;
   logic              busy;
   logic              done;
   logic              half_tick;
   logic              fall_tick;
   logic              boundary;
   logic              accept;
   logic              addr_more;
   logic              last_pass;

   // Volume is an arithmetic right shift of the signed sample; mute forces zero.
   function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] smp,
                                              input logic [2:0]       sh,
                                              input logic             mute);
      logic signed [WIDTH-1:0] s;
      s = $signed(smp);
      if (mute) begin
         return {WIDTH{1'b0}};
      end else begin
         return WIDTH'(s >>> sh);
      end
   endfunction

   assign half_tick = (div == DIV_W'(HALF_DIV - 1));
   assign fall_tick = half_tick & sclk;
   assign boundary  = fall_tick & (bit_cnt == BIT_W'(FW - 1));
   assign bit_next  = (bit_cnt == BIT_W'(FW - 1)) ? {BIT_W{1'b0}} : bit_cnt + BIT_W'(1);
   assign accept    = (state == S_IDLE) & bus.start & (bus.depth != {(ADDR_W+1){1'b0}});
   assign depth_m1  = depth_l - {{ADDR_W{1'b0}}, 1'b1};
   assign addr_more = ({1'b0, rom_addr} < depth_m1);
   assign pass_inc  = pass_cnt + 16'd1;
   assign last_pass = (repeats_l != 16'd0) & (pass_inc == repeats_l);
   // A stop arriving on the boundary cycle itself still silences that frame.
   assign stop_now  = stop_lat | (busy & bus.stop);

   // Frame content taken at a boundary: the processed sample only when a fetched
   // sample is waiting and no stop is pending, silence otherwise.
   always_comb begin
      frame_word = {FW{1'b0}};
      if ((state == S_WAIT) && !stop_now) begin
         frame_word = {scale(hold, bus.volume, bus.mute_l),
                       scale(hold, bus.volume, bus.mute_r)};
      end else begin
         frame_word = {FW{1'b0}};
      end
   end

   // Free-running SCLK divider: toggles SCLK every HALF_DIV MCLK cycles.
   always_ff @(posedge MCLK or posedge Reset) begin
      if (Reset) begin
         div  <= {DIV_W{1'b0}};
         sclk <= 1'b0;
      end else if (half_tick) begin
         div  <= {DIV_W{1'b0}};
         sclk <= ~sclk;
      end else begin
         div  <= div + DIV_W'(1);
      end
   end

   // Bit position, LRCLK and SD advance on SCLK falling edges; SD lags the
   // shift register by one bit period, giving the one-SCLK I2S delay.
   always_ff @(posedge MCLK or posedge Reset) begin
      if (Reset) begin
         bit_cnt <= {BIT_W{1'b0}};
         lrclk   <= 1'b0;
         sd      <= 1'b0;
         shreg   <= {FW{1'b0}};
      end else if (fall_tick) begin
         bit_cnt <= bit_next;
         lrclk   <= (bit_next >= BIT_W'(WIDTH));
         sd      <= shreg[FW-1];
         if (boundary) begin
            shreg <= frame_word;
         end else begin
            shreg <= {shreg[FW-2:0], 1'b0};
         end
      end
   end

   // Playback state register.
   always_ff @(posedge MCLK or posedge Reset) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Playback next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (accept) state_next = S_FETCH;
            else        state_next = S_IDLE;
         end
         S_FETCH: begin
            if (fetch_wait) state_next = S_WAIT;
            else            state_next = S_FETCH;
         end
         S_WAIT: begin
            if (boundary) state_next = S_LOAD;
            else          state_next = S_WAIT;
         end
         S_LOAD: begin
            if (stop_hit)       state_next = S_DONE;
            else if (addr_more) state_next = S_FETCH;
            else if (last_pass) state_next = S_DONE;
            else                state_next = S_FETCH;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Address, pass counting, sample holding, stop latch and status flags.
   always_ff @(posedge MCLK or posedge Reset) begin
      if (Reset) begin
         rom_addr   <= {ADDR_W{1'b0}};
         hold       <= {WIDTH{1'b0}};
         depth_l    <= {(ADDR_W+1){1'b0}};
         repeats_l  <= 16'd0;
         pass_cnt   <= 16'd0;
         stop_lat   <= 1'b0;
         stop_hit   <= 1'b0;
         fetch_wait <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done       <= (state_next == S_DONE) |
                       ((state == S_IDLE) & bus.start & (bus.depth == {(ADDR_W+1){1'b0}}));
         busy       <= (state_next != S_IDLE);
         fetch_wait <= (state == S_FETCH) & ~fetch_wait;
         if (busy && bus.stop) begin
            stop_lat <= 1'b1;
         end else if (!busy) begin
            stop_lat <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (accept) begin
                  rom_addr  <= {ADDR_W{1'b0}};
                  depth_l   <= bus.depth;
                  repeats_l <= bus.repeats;
                  pass_cnt  <= 16'd0;
                  stop_hit  <= 1'b0;
               end
            end
            S_FETCH: begin
               if (fetch_wait) hold <= bus.rom_data;
            end
            S_WAIT: begin
               if (boundary) stop_hit <= stop_now;
            end
            S_LOAD: begin
               if (!stop_hit) begin
                  if (addr_more) begin
                     rom_addr <= rom_addr + ADDR_W'(1);
                  end else begin
                     rom_addr <= {ADDR_W{1'b0}};
                     pass_cnt <= pass_inc;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.rom_addr = rom_addr;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.LRCLK    = lrclk;
   assign bus.SCLK     = sclk;
   assign bus.SD       = sd;
endmodule

// File: tb/tb_i2s_sequencer.sv
// Scoreboard bench: stimulus pushes expected {left,right} frames, a monitor
// decodes frames from SD and compares each non-silent frame in order.
module tb_i2s_sequencer;
   logic MCLK;
   logic Reset;

   i2s_sequencer_if #(.WIDTH(16), .ADDR_W(7)) bus1 ();
   i2s_sequencer_if #(.WIDTH(16), .ADDR_W(7)) bus2 ();

   i2s_sequencer #(.WIDTH(16), .HALF_DIV(2), .ADDR_W(7)) dut (
      .MCLK(MCLK), .Reset(Reset), .bus(bus1));
   i2s_sequencer #(.WIDTH(16), .HALF_DIV(10), .ADDR_W(7)) dut_slow (
      .MCLK(MCLK), .Reset(Reset), .bus(bus2));

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   int addr_chg = 0;
   logic [31:0] exp_q[$];
   logic [15:0] rom [0:127];

   logic [31:0] acc;
   logic        last_lr;
   logic        prev_sclk;
   logic [6:0]  prev_addr;
   logic [31:0] e;

   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   // Synchronous sample memory: data follows the address by one MCLK.
   always @(posedge MCLK) bus1.rom_data <= rom[bus1.rom_addr];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: decodes frames from SD on SCLK rising edges and checks them.
   always @(negedge MCLK) begin
      if (Reset) begin
         acc       = 32'h0;
         last_lr   = 1'b0;
         prev_sclk = 1'b0;
         prev_addr = 7'd0;
      end else begin
         if (bus1.SCLK && !prev_sclk) begin
            acc = {acc[30:0], bus1.SD};
            if (!bus1.LRCLK && last_lr && (acc != 32'h0)) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", acc, 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  check("frame", acc, e);
               end
            end
            last_lr = bus1.LRCLK;
         end
         prev_sclk = bus1.SCLK;
         if (bus1.rom_addr != prev_addr) addr_chg++;
         prev_addr = bus1.rom_addr;
      end
      if (bus1.done) done_cnt++;
   end

   task automatic do_start(input logic [7:0] d, input logic [15:0] r);
      @(negedge MCLK);
      bus1.start = 1'b1; bus1.depth = d; bus1.repeats = r;
      @(negedge MCLK);
      bus1.start = 1'b0;
   endtask

   task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
      exp_q.push_back({l, r});
   endtask

   task automatic wait_done(input int ref_cnt);
      for (int k = 0; k < 4000; k++) begin
         @(negedge MCLK);
         if (done_cnt > ref_cnt) break;
      end
   endtask

   task automatic wait_addr(input int target);
      for (int k = 0; k < 4000; k++) begin
         @(negedge MCLK);
         if (addr_chg >= target) break;
      end
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 4000 && exp_q.size() != 0; k++) @(negedge MCLK);
      check({name, "_drain"}, 32'(exp_q.size()), 32'h0);
      repeat (400) @(negedge MCLK);
   endtask

   function automatic logic sclk_of(input int w);
      return (w == 1) ? bus1.SCLK : bus2.SCLK;
   endfunction

   function automatic logic lr_of(input int w);
      return (w == 1) ? bus1.LRCLK : bus2.LRCLK;
   endfunction

   // SCLK period in MCLK cycles and LRCLK period in SCLK periods.
   task automatic meas(input int w, output int sp, output int lp);
      int c; logic ps; logic pl; bit armed;
      sp = 0; lp = 0; c = 0; armed = 1'b0; ps = sclk_of(w);
      for (int k = 0; k < 200; k++) begin
         @(negedge MCLK); c++;
         if (sclk_of(w) && !ps) begin
            if (armed) begin sp = c; break; end
            armed = 1'b1; c = 0;
         end
         ps = sclk_of(w);
      end
      c = 0; armed = 1'b0; ps = sclk_of(w); pl = lr_of(w);
      for (int k = 0; k < 3000; k++) begin
         @(negedge MCLK);
         if (sclk_of(w) && !ps) c++;
         if (!lr_of(w) && pl) begin
            if (armed) begin lp = c; break; end
            armed = 1'b1; c = 0;
         end
         ps = sclk_of(w); pl = lr_of(w);
      end
   endtask

   initial begin
      int ref_done; int ref_addr; int t1; int t2; int sp; int lp;
      for (int i = 0; i < 128; i++) rom[i] = 16'h0;
      bus1.start = 1'b0; bus1.stop = 1'b0; bus1.depth = 8'd0; bus1.repeats = 16'd0;
      bus1.volume = 3'd0; bus1.mute_l = 1'b0; bus1.mute_r = 1'b0;
      bus2.start = 1'b0; bus2.stop = 1'b0; bus2.depth = 8'd0; bus2.repeats = 16'd0;
      bus2.volume = 3'd0; bus2.mute_l = 1'b0; bus2.mute_r = 1'b0; bus2.rom_data = 16'h0;
      Reset = 1'b1;
      repeat (3) @(negedge MCLK);
      check("rst_rom_addr", 32'(bus1.rom_addr), 32'h0);
      check("rst_sclk",  32'(bus1.SCLK),  32'h0);
      check("rst_lrclk", 32'(bus1.LRCLK), 32'h0);
      check("rst_sd",    32'(bus1.SD),    32'h0);
      check("rst_busy",  32'(bus1.busy),  32'h0);
      check("rst_done",  32'(bus1.done),  32'h0);
      Reset = 1'b0;
      t1 = 0; t2 = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge MCLK);
         if (bus1.SCLK && t1 == 0) t1 = k;
         if (bus2.SCLK && t2 == 0) t2 = k;
      end
      check("first_rise_hd2", 32'(t1), 32'd2);
      check("first_rise_hd10", 32'(t2), 32'd10);

      // Basic playback, with an ignored start in the middle.
      rom[0] = 16'h1234; rom[1] = 16'h8000; rom[2] = 16'h7FFF; rom[3] = 16'h0001;
      for (int p = 0; p < 2; p++)
         for (int a = 0; a < 4; a++) push_frame(rom[a], rom[a]);
      ref_done = done_cnt;
      do_start(8'd4, 16'd2);
      check("basic_busy", 32'(bus1.busy), 32'h1);
      check("basic_addr0", 32'(bus1.rom_addr), 32'h0);
      @(negedge MCLK);
      ref_addr = addr_chg;
      wait_addr(ref_addr + 3);
      do_start(8'd1, 16'd1);
      wait_done(ref_done);
      @(negedge MCLK);
      check("basic_busy_low", 32'(bus1.busy), 32'h0);
      drain("basic");
      check("basic_done_cnt", 32'(done_cnt - ref_done), 32'h1);

      // Volume and mute.
      bus1.volume = 3'd5;
      rom[0] = 16'h8000; push_frame(16'hFC00, 16'hFC00);
      ref_done = done_cnt; do_start(8'd1, 16'd1); wait_done(ref_done); drain("vol_neg");
      rom[0] = 16'h7FFF; push_frame(16'h03FF, 16'h03FF);
      ref_done = done_cnt; do_start(8'd1, 16'd1); wait_done(ref_done); drain("vol_pos");
      bus1.mute_r = 1'b1; push_frame(16'h03FF, 16'h0000);
      ref_done = done_cnt; do_start(8'd1, 16'd1); wait_done(ref_done); drain("mute_r");
      bus1.volume = 3'd0; bus1.mute_r = 1'b0;

      // Stop during the 5th frame of an endless loop.
      rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333;
      push_frame(16'h1111, 16'h1111); push_frame(16'h2222, 16'h2222);
      push_frame(16'h3333, 16'h3333); push_frame(16'h1111, 16'h1111);
      push_frame(16'h2222, 16'h2222);
      ref_done = done_cnt;
      do_start(8'd3, 16'd0);
      @(negedge MCLK);
      ref_addr = addr_chg;
      wait_addr(ref_addr + 5);
      repeat (10) @(negedge MCLK);
      bus1.stop = 1'b1; @(negedge MCLK); bus1.stop = 1'b0;
      wait_done(ref_done);
      drain("stop");
      check("stop_done_cnt", 32'(done_cnt - ref_done), 32'h1);
      check("stop_busy_low", 32'(bus1.busy), 32'h0);

      // depth = 0: single done pulse, never busy.
      do_start(8'd0, 16'd1);
      check("d0_done", 32'(bus1.done), 32'h1);
      check("d0_busy", 32'(bus1.busy), 32'h0);
      @(negedge MCLK);
      check("d0_done_low", 32'(bus1.done), 32'h0);

      // depth = 1, repeats = 3.
      rom[0] = 16'h5A5A;
      for (int p = 0; p < 3; p++) push_frame(16'h5A5A, 16'h5A5A);
      ref_done = done_cnt; do_start(8'd1, 16'd3); wait_done(ref_done); drain("rep3");
      check("rep3_done_cnt", 32'(done_cnt - ref_done), 32'h1);

      // Reset during the second frame, then replay from address 0.
      rom[0] = 16'h0F0F; rom[1] = 16'hF0F0;
      push_frame(16'h0F0F, 16'h0F0F);
      ref_done = done_cnt;
      do_start(8'd2, 16'd0);
      @(negedge MCLK);
      ref_addr = addr_chg;
      wait_addr(ref_addr + 2);
      repeat (10) @(negedge MCLK);
      check("rst_pre_q", 32'(exp_q.size()), 32'h0);
      Reset = 1'b1;
      #1;
      check("midrst_sd",    32'(bus1.SD),    32'h0);
      check("midrst_sclk",  32'(bus1.SCLK),  32'h0);
      check("midrst_lrclk", 32'(bus1.LRCLK), 32'h0);
      check("midrst_busy",  32'(bus1.busy),  32'h0);
      repeat (3) @(negedge MCLK);
      Reset = 1'b0;
      repeat (5) @(negedge MCLK);
      check("midrst_no_done", 32'(done_cnt - ref_done), 32'h0);
      push_frame(16'h0F0F, 16'h0F0F); push_frame(16'hF0F0, 16'hF0F0);
      ref_done = done_cnt;
      do_start(8'd2, 16'd1);
      check("replay_addr0", 32'(bus1.rom_addr), 32'h0);
      wait_done(ref_done);
      drain("replay");

      // Serial clock and frame timing for both dividers.
      meas(1, sp, lp);
      check("sclk_per_hd2", 32'(sp), 32'd4);
      check("lrclk_per_hd2", 32'(lp), 32'd32);
      meas(2, sp, lp);
      check("sclk_per_hd10", 32'(sp), 32'd20);
      check("lrclk_per_hd10", 32'(lp), 32'd32);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
